// File: rtl/kv_store_arbiter.sv
// kv_store_arbiter
//   Shares one single-op-per-cycle key/value store between NUM_REQ requesters.
//   Round-robin grant in IDLE; read responses (1-cycle store latency) are routed
//   back to the requester that issued them via a one-deep tag register.
//   A clear command sweeps every key of the store to zero, then pulses clear_done.
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_valid/req_write          per-requester valid and 1=write/0=read
//   req_key/req_wdata            packed per-requester key and write data
//   req_ready                    one-hot grant (transfer on valid & ready)
//   rsp_valid/rsp_data           read response pulse to issuer, shared data bus
//   clear_req/busy/done          zero-sweep command, in-progress flag, finish pulse
//   st_*                         store control outputs and read-return inputs
module kv_store_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int KEY_W   = 4,
   parameter int DATA_W  = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*KEY_W-1:0]  req_key,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   input  logic                      clear_req,
   output logic                      clear_busy,
   output logic                      clear_done,
   output logic                      st_write_en,
   output logic                      st_read_en,
   output logic [KEY_W-1:0]          st_key,
   output logic [DATA_W-1:0]         st_data_in,
   input  logic [DATA_W-1:0]         st_data_out,
   input  logic                      st_data_valid
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [KEY_W-1:0] LAST_KEY = '1;

   typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  rr_q, rr_d;
   logic [KEY_W-1:0]  cnt_q, cnt_d;
   logic              tag_vld_q, tag_vld_d;
   logic [IDX_W-1:0]  tag_idx_q, tag_idx_d;

   logic              found;
   logic [IDX_W-1:0]  win;
   int                idx;
   logic              rsp_fire;

   // Round-robin search: first valid requester at or above rr_q, wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_q) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = IDX_W'(idx);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      cnt_d       = cnt_q;
      tag_vld_d   = 1'b0;
      tag_idx_d   = tag_idx_q;
      req_ready   = '0;
      st_write_en = 1'b0;
      st_read_en  = 1'b0;
      st_key      = '0;
      st_data_in  = '0;
      clear_busy  = 1'b0;
      clear_done  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clear_req) begin
               // Clear wins over any request presented this cycle.
               state_d = ST_CLEAR;
            end else if (found && reset_n) begin
               // reset_n gate keeps the combinational grant quiet while in reset.
               req_ready[win] = 1'b1;
               st_write_en    = req_write[win];
               st_read_en     = ~req_write[win];
               st_key         = req_key[int'(win)*KEY_W +: KEY_W];
               st_data_in     = req_wdata[int'(win)*DATA_W +: DATA_W];
               rr_d           = (int'(win) == NUM_REQ-1) ? '0 : win + 1'b1;
               tag_vld_d      = ~req_write[win];
               tag_idx_d      = win;
            end
         end
         ST_CLEAR: begin
            clear_busy  = 1'b1;
            st_write_en = 1'b1;
            st_key      = cnt_q;
            cnt_d       = cnt_q + 1'b1;
            if (cnt_q == LAST_KEY) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            clear_done = 1'b1;
            cnt_d      = '0;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Tag is rewritten every cycle, so only the read issued last cycle can respond;
   // a stray st_data_valid with no tag is ignored.
   assign rsp_fire = tag_vld_q & st_data_valid;

   always_comb begin
      rsp_valid = '0;
      if (rsp_fire) begin
         rsp_valid[tag_idx_q] = 1'b1;
      end
   end

   assign rsp_data = rsp_fire ? st_data_out : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         rr_q      <= '0;
         cnt_q     <= '0;
         tag_vld_q <= 1'b0;
         tag_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         cnt_q     <= cnt_d;
         tag_vld_q <= tag_vld_d;
         tag_idx_q <= tag_idx_d;
      end
   end

endmodule
